multicycle_control: RTL
=======================

# multicycle_control

Multicycle control FSM for the RV64 processor datapath. Sequences PC, instruction register, register file, immediate generator, ALU and the shared instruction/data memory port through fetch, decode, execute, memory and write-back phases for load (LD), store (SD), BEQ and R-type (ADD/SUB/AND/OR). Handles variable-latency memory with a req/ready handshake and a timeout. Sits between the instruction register and every datapath write enable and mux select.

## Interface
- TIMEOUT_CYCLES, 255: max wait cycles for mem_ready per access; 0 disables the timeout.
- CNT_W, 64: width of performance counters.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- ir  in  32  current instruction register contents
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write access (valid with mem_req)
- addr_src  out  1  memory address: 0 PC, 1 ALU result register
- ir_we, pc_we, reg_we, old_pc_we  out  1 each  datapath write enables
- pc_src  out  1  0 ALU result (PC+4), 1 ALU result register (branch target)
- alu_src_a  out  2  0 PC, 1 old PC, 2 rs1
- alu_src_b  out  2  0 rs2, 1 immediate, 2 constant 4
- alu_op  out  2  0 ADD, 1 SUB, 2 AND, 3 OR
- wb_src  out  1  0 ALU, 1 memory data
- halted  out  1  FSM in HALT
- fault  out  2  0 none, 1 illegal opcode/funct, 2 memory timeout
- cycle_cnt, instret  out  CNT_W each  performance counters

## Operation
- States: IDLE, FETCH, DECODE, MEMADDR, MEM_RD, MEM_WR, WB_MEM, EXEC_R, WB_ALU, BRANCH, HALT. Moore outputs, except pc_we (BRANCH, qualified by zero) and ir_we/pc_we/old_pc_we in FETCH (qualified by mem_ready).
- IDLE: all outputs 0; next FETCH.
- FETCH: mem_req=1, addr_src=0, alu A=PC, B=4, ADD. On mem_ready: ir_we, old_pc_we, pc_we (pc_src=0) → DECODE; else stay.
- DECODE: A=old PC, B=imm, ADD (branch target into ALU result register). Opcode ir[6:0]: 0000011 → MEMADDR; 0100011 → MEMADDR; 1100011 → BRANCH; 0110011 → EXEC_R; else HALT, fault=1.
- MEMADDR: A=rs1, B=imm, ADD; → MEM_RD (ir[5]=0) or MEM_WR (ir[5]=1).
- MEM_RD: mem_req, addr_src=1; on ready → WB_MEM. WB_MEM: reg_we, wb_src=1 → FETCH.
- MEM_WR: mem_req, mem_we, addr_src=1; on ready → FETCH.
- EXEC_R: A=rs1, B=rs2; funct3/funct7: 000/0000000 ADD, 000/0100000 SUB, 111/0000000 AND, 110/0000000 OR; other → HALT, fault=1. → WB_ALU: reg_we, wb_src=0 → FETCH.
- BRANCH: A=rs1, B=rs2, SUB; pc_we=zero, pc_src=1 → FETCH.
- HALT: all enables and mem_req 0; halted=1; fault held; exit only by reset.
- Wait counter: counts cycles in FETCH/MEM_RD/MEM_WR with mem_ready=0; cleared on ready or state change. Reaching TIMEOUT_CYCLES → HALT, fault=2. mem_ready in same cycle as limit wins (access completes).

## Timing
- Reset: state IDLE, every output 0, counters 0, fault 0.
- Zero-wait latency: BEQ 3, R-type 4, SD 4, LD 5 cycles; each wait cycle adds 1.
- mem_req stays high until the cycle mem_ready=1; mem_ready outside a request is ignored.
- Reset mid-access drops mem_req asynchronously.

## Configuration
- RISCV_CTRL_PERF_EN defined: cycle_cnt increments every cycle outside IDLE/HALT; instret increments on every transition into FETCH from WB_MEM, MEM_WR, WB_ALU, BRANCH. Both wrap at 2^CNT_W.
- Undefined: counters not built; ports driven 0.

## Structure
- Package riscv_ctrl_pkg: state enum, opcode/funct constants, alu_op, alu_src and fault encodings.
- Sub-module mem_wait_timer: wait counter and timeout comparator.

## Test plan
- Reset, ADD x3 (0x002081B3), zero-wait → IDLE,FETCH,DECODE,EXEC_R,WB_ALU; alu_op=0, reg_we=1 in cycle 5.
- LD (0x0000B103), mem_ready delayed 3 cycles in MEM_RD → mem_req held 4 cycles, reg_we with wb_src=1 once.
- BEQ (0x00208463) with zero=1 then zero=0 → pc_we=1, pc_src=1 first; pc_we=0 second.
- Opcode 0x7F or funct7=0x01 R-type → HALT, fault=1, halted=1 until reset.
- mem_ready never asserted, TIMEOUT_CYCLES=4 → HALT after 4 wait cycles, fault=2; reset asserted mid-access clears mem_req immediately.
- RISCV_CTRL_PERF_EN: 10 instructions → instret=10, cycle_cnt equals summed latencies.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the RV64 multicycle control unit: FSM state encoding,
// the opcode/funct values the controller recognises, datapath mux encodings,
// fault codes and a small R-type funct decoder.
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_MEM,
    S_EXEC_R,
    S_WB_ALU,
    S_BRANCH,
    S_HALT
  } state_t;

  // Major opcodes (ir[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  // R-type function fields
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'd0,
    SRC_A_OLD_PC = 2'd1,
    SRC_A_RS1    = 2'd2
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } alu_src_b_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_ILLEGAL = 2'd1,
    FAULT_TIMEOUT = 2'd2
  } fault_t;

  typedef struct packed {
    logic    legal;
    alu_op_t op;
  } rtype_dec_t;

  // Maps funct3/funct7 of an R-type instruction to an ALU operation.
  // Anything outside ADD/SUB/AND/OR is flagged illegal.
  function automatic rtype_dec_t decode_rtype(input logic [2:0] funct3,
                                              input logic [6:0] funct7);
    rtype_dec_t d;
    d.legal = 1'b1;
    d.op    = ALU_ADD;
    case ({funct7, funct3})
      {F7_BASE, F3_ADD_SUB}: d.op = ALU_ADD;
      {F7_SUB,  F3_ADD_SUB}: d.op = ALU_SUB;
      {F7_BASE, F3_AND}:     d.op = ALU_AND;
      {F7_BASE, F3_OR}:      d.op = ALU_OR;
      default:               d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive cycles a memory request is outstanding without mem_ready
// and flags the cycle in which that count reaches TIMEOUT_CYCLES.
//
// Parameters
//   TIMEOUT_CYCLES  wait cycles allowed per access; 0 disables the timeout
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high
//   active   in   controller is in a state that issues mem_req
//   ready    in   memory completes the access this cycle
//   timeout  out  this is the TIMEOUT_CYCLES-th wait cycle of the access
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  // Counter holds the number of earlier wait cycles, so it only has to reach
  // TIMEOUT_CYCLES-1.
  localparam int unsigned CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit ENABLE          = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt;
  logic          waiting;

  assign waiting = active & ~ready;

  // A wait state is only left through ready (clears here) or a timeout into
  // HALT (inactive, clears next cycle), so "not waiting" covers every state
  // change as well.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (waiting) cnt <= cnt + CW'(1);
    else              cnt <= '0;
  end

  // ready in the limit cycle keeps waiting low, so completion wins.
  assign timeout = ENABLE && waiting && (cnt == LAST);

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Control FSM for the multicycle RV64 datapath. Sequences fetch, decode,
// execute, memory and write-back for LD, SD, BEQ and R-type ADD/SUB/AND/OR,
// using a req/ready handshake on the shared memory port with a wait timeout.
//
// Build option: define RISCV_CTRL_PERF_EN to build the cycle_cnt/instret
// performance counters; otherwise both ports are tied to zero.
//
// Parameters
//   TIMEOUT_CYCLES  max wait cycles for mem_ready per access (0 = no timeout)
//   CNT_W           performance counter width
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   ir                         instruction register contents
//   zero                       ALU zero flag (branch compare)
//   mem_ready                  memory completes the access this cycle
//   mem_req, mem_we, addr_src  memory request, write, address select
//   ir_we, pc_we, reg_we,
//   old_pc_we                  datapath write enables
//   pc_src                     0 ALU result, 1 ALU result register
//   alu_src_a                  0 PC, 1 old PC, 2 rs1
//   alu_src_b                  0 rs2, 1 immediate, 2 constant 4
//   alu_op                     0 ADD, 1 SUB, 2 AND, 3 OR
//   wb_src                     0 ALU, 1 memory data
//   halted, fault              HALT indication and its cause
//   cycle_cnt, instret         performance counters
// -----------------------------------------------------------------------------
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_src,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             old_pc_we,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             wb_src,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  state_t     state_q, state_d;
  fault_t     fault_q, fault_d;
  alu_src_a_t a_sel;
  alu_src_b_t b_sel;
  alu_op_t    op_sel;
  rtype_dec_t rdec;
  logic       mem_active;
  logic       mem_timeout;

  // Register index and immediate bits belong to the datapath only.
  logic unused_ir;
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  assign rdec = decode_rtype(ir[14:12], ir[31:25]);

  // Derived from the state register alone so the timeout path does not loop
  // back through the output logic.
  assign mem_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                      (state_q == S_MEM_WR);

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .active (mem_active),
    .ready  (mem_ready),
    .timeout(mem_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_src  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_we    = 1'b0;
    old_pc_we = 1'b0;
    pc_src    = 1'b0;
    wb_src    = 1'b0;
    a_sel     = SRC_A_PC;
    b_sel     = SRC_B_RS2;
    op_sel    = ALU_ADD;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // PC+4 is computed while the instruction is read; PC, old PC and IR
      // all update together in the cycle the memory delivers.
      S_FETCH: begin
        mem_req = 1'b1;
        a_sel   = SRC_A_PC;
        b_sel   = SRC_B_FOUR;
        if (mem_ready) begin
          ir_we     = 1'b1;
          old_pc_we = 1'b1;
          pc_we     = 1'b1;
          state_d   = S_DECODE;
        end else if (mem_timeout) begin
          state_d = S_HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end

      // Branch target (old PC + imm) lands in the ALU result register here.
      S_DECODE: begin
        a_sel = SRC_A_OLD_PC;
        b_sel = SRC_B_IMM;
        case (ir[6:0])
          OP_LOAD, OP_STORE: state_d = S_MEMADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_RTYPE:          state_d = S_EXEC_R;
          default: begin
            state_d = S_HALT;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end

      // ir[5] separates SD (0100011) from LD (0000011).
      S_MEMADDR: begin
        a_sel   = SRC_A_RS1;
        b_sel   = SRC_B_IMM;
        state_d = ir[5] ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (mem_timeout) begin
          state_d = S_HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end

      S_WB_MEM: begin
        reg_we  = 1'b1;
        wb_src  = 1'b1;
        state_d = S_FETCH;
      end

      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (mem_timeout) begin
          state_d = S_HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end

      S_EXEC_R: begin
        a_sel = SRC_A_RS1;
        b_sel = SRC_B_RS2;
        if (rdec.legal) begin
          op_sel  = rdec.op;
          state_d = S_WB_ALU;
        end else begin
          state_d = S_HALT;
          fault_d = FAULT_ILLEGAL;
        end
      end

      S_WB_ALU: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end

      // rs1 - rs2 sets zero; on equality the stored target is loaded.
      S_BRANCH: begin
        a_sel   = SRC_A_RS1;
        b_sel   = SRC_B_RS2;
        op_sel  = ALU_SUB;
        pc_src  = 1'b1;
        pc_we   = zero;
        state_d = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

  assign alu_src_a = a_sel;
  assign alu_src_b = b_sel;
  assign alu_op    = op_sel;
  assign halted    = (state_q == S_HALT);
  assign fault     = fault_q;

`ifdef RISCV_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             running, retire;

  assign running = (state_q != S_IDLE) && (state_q != S_HALT);
  // Retirement is the hop back to FETCH from a final state of an instruction.
  assign retire  = (state_d == S_FETCH) &&
                   ((state_q == S_WB_MEM) || (state_q == S_MEM_WR) ||
                    (state_q == S_WB_ALU) || (state_q == S_BRANCH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (running) cycle_q   <= cycle_q + CNT_W'(1);
      if (retire)  instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign instret   = instret_q;
`else
  assign cycle_cnt = '0;
  assign instret   = '0;
`endif

endmodule
